// File: rtl/apb_master_arbiter_if.sv
// Bundle between the round-robin APB master and its environment.
// Carries requester commands/responses plus the APB4 bus; master = arbiter view.
interface apb_master_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*4-1:0]  req_strb;
    logic [NREQ-1:0]    done;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic               PSELx;
    logic               PENABLE;
    logic               PWRITE;
    logic [31:0]        PADDR;
    logic [31:0]        PWDATA;
    logic [3:0]         PSTRB;
    logic [31:0]        PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    modport master (
        input  req, req_write, req_addr, req_wdata, req_strb,
        input  PRDATA, PREADY, PSLVERR,
        output done, rsp_rdata, rsp_err,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, req_strb,
        output PRDATA, PREADY, PSLVERR,
        input  done, rsp_rdata, rsp_err,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin APB4 master shared by NREQ requesters, with PREADY timeout.
// Ports: PCLK, PRESETn (sync, active-low), bus (apb_master_arbiter_if.master).
module apb_master_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_master_arbiter_if.master bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   ptr_q;
    logic [GW-1:0]   gnt_q;
    logic [CW-1:0]   cnt_q;
    logic            psel_q;
    logic            pen_q;
    logic            pwrite_q;
    logic [31:0]     paddr_q;
    logic [31:0]     pwdata_q;
    logic [3:0]      pstrb_q;
    logic [NREQ-1:0] done_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic [GW-1:0]   gnt_d;
    logic [GW-1:0]   cand;
    logic            found;

    // First pending requester after the last winner, wrapping at NREQ.
    always_comb begin
        gnt_d = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                gnt_d = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            ptr_q    <= GW'(NREQ - 1);
            gnt_q    <= '0;
            cnt_q    <= '0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            done_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        gnt_q    <= gnt_d;
                        ptr_q    <= gnt_d;
                        pwrite_q <= bus.req_write[gnt_d];
                        paddr_q  <= bus.req_addr[{gnt_d, 5'b0} +: 32];
                        pwdata_q <= bus.req_wdata[{gnt_d, 5'b0} +: 32];
                        pstrb_q  <= bus.req_write[gnt_d] ?
                                    bus.req_strb[{gnt_d, 2'b0} +: 4] : 4'b0;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    pen_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        rdata_q        <= pwrite_q ? 32'h0 : bus.PRDATA;
                        err_q          <= bus.PSLVERR;
                        psel_q         <= 1'b0;
                        pen_q          <= 1'b0;
                        done_q[gnt_q]  <= 1'b1;
                        state_q        <= RESP;
                    end else begin
                        if (cnt_q != TMAX) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        // This cycle is the TIMEOUT-th one with PREADY low.
                        if ((TIMEOUT > 0) && (cnt_q == TLAST)) begin
                            rdata_q       <= '0;
                            err_q         <= 1'b1;
                            psel_q        <= 1'b0;
                            pen_q         <= 1'b0;
                            done_q[gnt_q] <= 1'b1;
                            state_q       <= RESP;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.PSELx     = psel_q;
    assign bus.PENABLE   = pen_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.done      = done_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter (NREQ=2, TIMEOUT=4).
// Expected responses are queued at stimulus time and popped on done.
module tb_apb_master_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    typedef struct {
        int          g;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    apb_master_arbiter_if #(.NREQ(2)) bus ();

    apb_master_arbiter #(.NREQ(2), .TIMEOUT(4)) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, output int n, output bit ok);
        n = 0;
        while (bus.done == 2'b00 && n < maxc) begin
            tick();
            n++;
        end
        ok = (bus.done != 2'b00);
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        bus.req_write[i]         = w;
        bus.req_addr[32*i +: 32] = a;
        bus.req_wdata[32*i +: 32] = d;
        bus.req_strb[4*i +: 4]   = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.PSELx, bus.PENABLE, bus.PWRITE} !== 3'b000 ||
            bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0 ||
            bus.PSTRB !== 4'h0 || bus.done !== 2'b00 ||
            bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: psel=%b pen=%b paddr=%h done=%b required all zero",
                     bus.PSELx, bus.PENABLE, bus.PADDR, bus.done);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        set_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
        bus.PREADY = 1'b1;
        bus.PSLVERR = 1'b0;
        bus.PRDATA = 32'hA5A5_0001;
        bus.req = 2'b01;
        sb.push_back('{0, 32'hA5A5_0001, 1'b0});
        tick();
        checks++;
        if ({bus.PSELx, bus.PENABLE} !== 2'b10 || bus.PADDR !== 32'h10 ||
            bus.PSTRB !== 4'h0 || bus.PWRITE !== 1'b0) begin
            failures++;
            $display("FAIL single_setup: sel/en=%b%b paddr=%h strb=%h required 10 00000010 0",
                     bus.PSELx, bus.PENABLE, bus.PADDR, bus.PSTRB);
        end
        tick();
        checks++;
        if ({bus.PSELx, bus.PENABLE} !== 2'b11) begin
            failures++;
            $display("FAIL single_access: sel/en=%b%b required 11", bus.PSELx, bus.PENABLE);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.done !== 2'b01 || bus.rsp_rdata !== e.rdata ||
            bus.rsp_err !== e.err || bus.PSELx !== 1'b0) begin
            failures++;
            $display("FAIL single_done: done=%b rdata=%h err=%b psel=%b required 01 %h %b 0",
                     bus.done, bus.rsp_rdata, bus.rsp_err, bus.PSELx, e.rdata, e.err);
        end
        bus.req = 2'b00;
        tick();
        checks++;
        if (bus.done !== 2'b00) begin
            failures++;
            $display("FAIL single_pulse: done=%b required 00", bus.done);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        int   n;
        bit   ok;
        logic [31:0] addrs [2];
        addrs[0] = 32'h100;
        addrs[1] = 32'h204;
        do_reset();
        set_req(0, 1'b0, addrs[0], 32'h0, 4'h0);
        set_req(1, 1'b0, addrs[1], 32'h0, 4'h0);
        bus.PREADY = 1'b1;
        bus.req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            bus.PRDATA = 32'hC000_0000 | t;
            sb.push_back('{t % 2, 32'hC000_0000 | t, 1'b0});
            if (t > 0) tick();
            wait_done(10, n, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || bus.done !== (2'b01 << e.g) || bus.rsp_rdata !== e.rdata ||
                bus.PADDR !== addrs[e.g]) begin
                failures++;
                $display("FAIL contention_grant%0d: done=%b rdata=%h paddr=%h required %b %h %h",
                         t, bus.done, bus.rsp_rdata, bus.PADDR, 2'b01 << e.g,
                         e.rdata, addrs[e.g]);
            end
            if (t > 0) begin
                checks++;
                if (n + 1 != 4) begin
                    failures++;
                    $display("FAIL contention_spacing%0d: cycles=%0d required 4", t, n + 1);
                end
            end
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_wait_error();
        exp_t e;
        set_req(1, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011);
        bus.PREADY = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA = 32'h5555_AAAA;
        bus.req = 2'b10;
        sb.push_back('{1, 32'h0, 1'b1});
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({bus.PSELx, bus.PENABLE} !== 2'b11 || bus.PWDATA !== 32'hDEAD_BEEF ||
                bus.PSTRB !== 4'b0011 || bus.PWRITE !== 1'b1 || bus.done !== 2'b00) begin
                failures++;
                $display("FAIL wait_access%0d: en=%b wdata=%h strb=%b done=%b required 1 deadbeef 0011 00",
                         k, bus.PENABLE, bus.PWDATA, bus.PSTRB, bus.done);
            end
            if (k == 3) begin
                bus.PREADY = 1'b1;
                bus.PSLVERR = 1'b1;
            end
            tick();
        end
        e = sb.pop_front();
        checks++;
        if (bus.done !== 2'b10 || bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
            failures++;
            $display("FAIL wait_done_cycle6: done=%b err=%b rdata=%h required 10 %b %h",
                     bus.done, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
        end
        bus.req = 2'b00;
        bus.PREADY = 1'b0;
        bus.PSLVERR = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n;
        set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hFFFF_0000;
        bus.req = 2'b01;
        sb.push_back('{0, 32'h0, 1'b1});
        tick();
        tick();
        n = 0;
        while (bus.PSELx && bus.PENABLE && n < 20) begin
            n++;
            tick();
        end
        e = sb.pop_front();
        checks++;
        if (n != 4 || bus.done !== 2'b01 || bus.rsp_err !== e.err ||
            bus.rsp_rdata !== e.rdata || bus.PSELx !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort: access=%0d done=%b err=%b rdata=%h psel=%b required 4 01 1 0 0",
                     n, bus.done, bus.rsp_err, bus.rsp_rdata, bus.PSELx);
        end
        bus.req = 2'b00;
        tick();
        bus.req = 2'b01;
        bus.PRDATA = 32'h1234_5678;
        sb.push_back('{0, 32'h1234_5678, 1'b0});
        tick();
        tick();
        for (int k = 0; k < 3; k++) tick();
        bus.PREADY = 1'b1;
        bus.PSLVERR = 1'b0;
        checks++;
        if ({bus.PSELx, bus.PENABLE} !== 2'b11) begin
            failures++;
            $display("FAIL timeout_4th_access: sel/en=%b%b required 11", bus.PSELx, bus.PENABLE);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.done !== 2'b01 || bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
            failures++;
            $display("FAIL timeout_pready_wins: done=%b err=%b rdata=%h required 01 %b %h",
                     bus.done, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
        end
        bus.req = 2'b00;
        bus.PREADY = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        bit   ok;
        set_req(1, 1'b1, 32'h500, 32'h7777_8888, 4'hF);
        bus.PREADY = 1'b0;
        bus.req = 2'b10;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.PSELx, bus.PENABLE, bus.PWRITE} !== 3'b000 || bus.PADDR !== 32'h0 ||
            bus.PWDATA !== 32'h0 || bus.PSTRB !== 4'h0 || bus.done !== 2'b00 ||
            bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: psel=%b pen=%b paddr=%h wdata=%h done=%b required zeros",
                     bus.PSELx, bus.PENABLE, bus.PADDR, bus.PWDATA, bus.done);
        end
        set_req(0, 1'b0, 32'h600, 32'h0, 4'h0);
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h0BAD_F00D;
        bus.req = 2'b11;
        rst_n = 1'b1;
        sb.push_back('{0, 32'h0BAD_F00D, 1'b0});
        wait_done(10, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || bus.done !== 2'b01 || bus.rsp_rdata !== e.rdata || bus.PADDR !== 32'h600) begin
            failures++;
            $display("FAIL reset_first_grant: done=%b rdata=%h paddr=%h required 01 %h 00000600",
                     bus.done, bus.rsp_rdata, bus.PADDR, e.rdata);
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_withdrawal();
        exp_t e;
        int   n;
        bit   ok;
        int   d1;
        int   psel_seen;
        set_req(0, 1'b0, 32'h700, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h704, 32'h0, 4'h0);
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h0000_CAFE;
        bus.req = 2'b01;
        sb.push_back('{0, 32'h0000_CAFE, 1'b0});
        tick();
        bus.req = 2'b11;
        tick();
        bus.req = 2'b01;
        bus.PREADY = 1'b1;
        wait_done(10, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || bus.done !== 2'b01 || bus.rsp_rdata !== e.rdata) begin
            failures++;
            $display("FAIL withdraw_req0: done=%b rdata=%h required 01 %h",
                     bus.done, bus.rsp_rdata, e.rdata);
        end
        bus.req = 2'b00;
        d1 = 0;
        psel_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.done[1]) d1++;
            if (bus.PSELx) psel_seen++;
        end
        checks++;
        if (d1 != 0 || psel_seen != 0) begin
            failures++;
            $display("FAIL withdraw_req1: done1=%0d psel=%0d required 0 0", d1, psel_seen);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_write = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_strb = '0;
        bus.PRDATA = '0;
        bus.PREADY = 1'b0;
        bus.PSLVERR = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_wait_error();
        test_timeout();
        test_reset_mid();
        test_withdrawal();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
